// File: rtl/vdp_reg_write_arbiter_pkg.sv
// Shared constants and types for the VDP register write arbiter.
// Optional build macro used by the arbiter: VDP_REG_ARB_STATS_EN.
`include "vdp_reg_arb.vh"

package vdp_reg_write_arbiter_pkg;

    localparam int VDP_ADDR_WIDTH = `VDP_REG_ADDR_WIDTH;
    localparam int VDP_DATA_WIDTH = `VDP_REG_DATA_WIDTH;
    localparam int VDP_FIFO_DEPTH = `VDP_REG_FIFO_DEPTH;

    // Which requester owns the register-file write port this cycle.
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_HOST,
        SRC_COPPER
    } write_src_e;

endpackage

// File: rtl/vdp_reg_write_arbiter_if.sv
// Bus bundle between host/copper write sources, the arbiter and the register file.
// copper_stall_count exists only when VDP_REG_ARB_STATS_EN is defined.
interface vdp_reg_write_arbiter_if #(
    parameter int ADDR_WIDTH = vdp_reg_write_arbiter_pkg::VDP_ADDR_WIDTH,
    parameter int DATA_WIDTH = vdp_reg_write_arbiter_pkg::VDP_DATA_WIDTH
);
    logic                  host_write_en;
    logic [ADDR_WIDTH-1:0] host_write_address;
    logic [DATA_WIDTH-1:0] host_write_data;
    logic                  copper_write_en;
    logic [ADDR_WIDTH-1:0] copper_write_address;
    logic [DATA_WIDTH-1:0] copper_write_data;
    logic                  copper_write_ready;
    logic                  copper_flush;
    logic                  reg_write_en;
    logic [ADDR_WIDTH-1:0] reg_write_address;
    logic [DATA_WIDTH-1:0] reg_write_data;
    logic                  copper_overflow;
`ifdef VDP_REG_ARB_STATS_EN
    logic [15:0]           copper_stall_count;
`endif

    modport master (
        output host_write_en, host_write_address, host_write_data,
        output copper_write_en, copper_write_address, copper_write_data, copper_flush,
        input  copper_write_ready, reg_write_en, reg_write_address, reg_write_data,
        input  copper_overflow
`ifdef VDP_REG_ARB_STATS_EN
        , input copper_stall_count
`endif
    );

    modport slave (
        input  host_write_en, host_write_address, host_write_data,
        input  copper_write_en, copper_write_address, copper_write_data, copper_flush,
        output copper_write_ready, reg_write_en, reg_write_address, reg_write_data,
        output copper_overflow
`ifdef VDP_REG_ARB_STATS_EN
        , output copper_stall_count
`endif
    );

endinterface

// File: rtl/vdp_reg_arb.vh
// Register-file geometry shared by the copper, the register file and the write arbiter.
// Optional build macro used by the arbiter: VDP_REG_ARB_STATS_EN.
`ifndef VDP_REG_ARB_VH
`define VDP_REG_ARB_VH

`define VDP_REG_ADDR_WIDTH 6
`define VDP_REG_DATA_WIDTH 16
`define VDP_REG_FIFO_DEPTH 4

`endif

// File: rtl/vdp_reg_write_fifo.sv
// Small synchronous FIFO holding buffered copper register writes.
// DEPTH must be a power of two so the pointers wrap naturally.
module vdp_reg_write_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 22
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Flush behaves like a reset of the bookkeeping; stored data is simply abandoned.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/vdp_reg_write_arbiter.sv
// Merges host and buffered copper writes onto the single VDP register-file write port.
// Define VDP_REG_ARB_STATS_EN to add the copper_stall_count statistic.
module vdp_reg_write_arbiter
    import vdp_reg_write_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = VDP_FIFO_DEPTH,
    parameter int ADDR_WIDTH = VDP_ADDR_WIDTH,
    parameter int DATA_WIDTH = VDP_DATA_WIDTH
) (
    input logic                    clk,
    input logic                    reset,
    vdp_reg_write_arbiter_if.slave bus
);
    localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ENTRY_W-1:0]    fifo_head;
    logic                  push;
    logic                  pop;
    write_src_e            src;
    logic                  out_en;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  overflow;

    // Ready comes from registered occupancy only, so a same-cycle pop never frees a slot.
    assign bus.copper_write_ready = !fifo_full;
    assign push = bus.copper_write_en && !fifo_full && !bus.copper_flush;
    assign pop  = (src == SRC_COPPER);

    always_comb begin
        src = SRC_NONE;
        if (bus.host_write_en)
            src = SRC_HOST;
        else if (!fifo_empty && !bus.copper_flush)
            src = SRC_COPPER;
    end

    vdp_reg_write_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (bus.copper_flush),
        .push_data ({bus.copper_write_address, bus.copper_write_data}),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // Address and data hold their last values on idle cycles; only the strobe drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_en   <= 1'b0;
            out_addr <= '0;
            out_data <= '0;
            overflow <= 1'b0;
        end else begin
            out_en <= (src != SRC_NONE);
            case (src)
                SRC_HOST: begin
                    out_addr <= bus.host_write_address;
                    out_data <= bus.host_write_data;
                end
                SRC_COPPER: {out_addr, out_data} <= fifo_head;
                default: ;
            endcase
            if (bus.copper_write_en && fifo_full && !bus.copper_flush)
                overflow <= 1'b1;
        end
    end

    assign bus.reg_write_en      = out_en;
    assign bus.reg_write_address = out_addr;
    assign bus.reg_write_data    = out_data;
    assign bus.copper_overflow   = overflow;

`ifdef VDP_REG_ARB_STATS_EN
    logic [15:0] stall_count;

    // Counts cycles where buffered copper work was held off by a host write.
    always_ff @(posedge clk) begin
        if (reset || bus.copper_flush)
            stall_count <= '0;
        else if (!fifo_empty && bus.host_write_en && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
    end

    assign bus.copper_stall_count = stall_count;
`endif

endmodule

// File: tb/tb_vdp_reg_write_arbiter.sv
// Self-checking bench for vdp_reg_write_arbiter: per-cycle vector table plus an ordered write scoreboard.
module tb_vdp_reg_write_arbiter;
    import vdp_reg_write_arbiter_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    vdp_reg_write_arbiter_if bus ();

    vdp_reg_write_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // One row = inputs for one cycle, ready before the edge, strobe/overflow after it.
    typedef struct {
        bit          rst;
        bit          flush;
        bit          he;
        logic [5:0]  ha;
        logic [15:0] hd;
        bit          ce;
        logic [5:0]  ca;
        logic [15:0] cd;
        bit          erdy;
        bit          ewen;
        logic [5:0]  ea;
        logic [15:0] ed;
        bit          eovf;
    } vec_t;

    typedef struct packed {
        logic [5:0]  a;
        logic [15:0] d;
    } wr_t;

    vec_t vecs[$];
    wr_t  sbq[$];
    int   nvec  = 0;
    int   nfail = 0;

    function automatic vec_t mk(int rst, int fl, int he, int ha, int hd, int ce, int ca, int cd,
                                int rdy, int wen, int ea, int ed, int ovf);
        vec_t v;
        v.rst  = 1'(rst);
        v.flush = 1'(fl);
        v.he   = 1'(he);
        v.ha   = 6'(ha);
        v.hd   = 16'(hd);
        v.ce   = 1'(ce);
        v.ca   = 6'(ca);
        v.cd   = 16'(cd);
        v.erdy = 1'(rdy);
        v.ewen = 1'(wen);
        v.ea   = 6'(ea);
        v.ed   = 16'(ed);
        v.eovf = 1'(ovf);
        return v;
    endfunction

    task automatic compare(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(vec_t v);
        reset                    = v.rst;
        bus.copper_flush         = v.flush;
        bus.host_write_en        = v.he;
        bus.host_write_address   = v.ha;
        bus.host_write_data      = v.hd;
        bus.copper_write_en      = v.ce;
        bus.copper_write_address = v.ca;
        bus.copper_write_data    = v.cd;
        if (v.ewen)
            sbq.push_back('{a: v.ea, d: v.ed});
    endtask

    task automatic checkOutput(vec_t v, int idx);
        wr_t exp;
        compare($sformatf("v%0d reg_write_en", idx), 32'(bus.reg_write_en), 32'(v.ewen));
        compare($sformatf("v%0d copper_overflow", idx), 32'(bus.copper_overflow), 32'(v.eovf));
        if (bus.reg_write_en === 1'b1) begin
            if (sbq.size() == 0) begin
                nvec++;
                nfail++;
                $display("[TB] FAIL v%0d unexpected write: got 0x%0h=0x%0h, expected no write",
                         idx, bus.reg_write_address, bus.reg_write_data);
            end else begin
                exp = sbq.pop_front();
                compare($sformatf("v%0d write addr", idx), 32'(bus.reg_write_address), 32'(exp.a));
                compare($sformatf("v%0d write data", idx), 32'(bus.reg_write_data), 32'(exp.d));
            end
        end
        if (v.rst) begin
            compare($sformatf("v%0d reset addr", idx), 32'(bus.reg_write_address), 32'd0);
            compare($sformatf("v%0d reset data", idx), 32'(bus.reg_write_data), 32'd0);
        end
    endtask

    initial begin
        applyStimulus(mk(1,0,0,0,0,0,0,0, 1,0,0,0,0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare("reset reg_write_en", 32'(bus.reg_write_en), 32'd0);
        compare("reset addr", 32'(bus.reg_write_address), 32'd0);
        compare("reset data", 32'(bus.reg_write_data), 32'd0);
        compare("reset ready", 32'(bus.copper_write_ready), 32'd1);
        compare("reset overflow", 32'(bus.copper_overflow), 32'd0);

        // Host-only write
        vecs.push_back(mk(0,0,1,'h05,'h1234,0,0,0, 1,1,'h05,'h1234,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,0,0,0,0));
        // Copper burst with host idle: 2-cycle latency, back-to-back output
        vecs.push_back(mk(0,0,0,0,0,1,'h10,'h000A, 1,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,'h11,'h000B, 1,1,'h10,'h000A,0));
        vecs.push_back(mk(0,0,0,0,0,1,'h12,'h000C, 1,1,'h11,'h000B,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,1,'h12,'h000C,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,0,0,0,0));
        // Collision: host first, copper next
        vecs.push_back(mk(0,0,1,'h21,'h0002,1,'h20,'h0001, 1,1,'h21,'h0002,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,1,'h20,'h0001,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,0,0,0,0));
        // Overflow: host busy, five copper pushes into four slots
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0,0,1,'h30+i,'h0100+i,1,'h08+i,'hC008+i,
                              (i < 4) ? 1 : 0, 1,'h30+i,'h0100+i, (i == 4) ? 1 : 0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,1,'h08,'hC008,1));
        vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,1,'h09,'hC009,1));
        vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,1,'h0A,'hC00A,1));
        vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,1,'h0B,'hC00B,1));
        vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,0,0,0,1));
        // Reset clears overflow
        vecs.push_back(mk(1,0,0,0,0,0,0,0, 1,0,0,0,0));
        // Flush with a same-cycle push after filling three entries
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,0,1,'h38+i,'h1111*(i+1),1,'h01+i,'hF001+i, 1,1,'h38+i,'h1111*(i+1),0));
        vecs.push_back(mk(0,1,0,0,0,1,'h04,'hF004, 1,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,0,0,0,0));
        // Flush with a host write: only the host write emerges
        vecs.push_back(mk(0,0,1,'h3B,'h4444,1,'h05,'hF005, 1,1,'h3B,'h4444,0));
        vecs.push_back(mk(0,1,1,'h3C,'h5555,0,0,0, 1,1,'h3C,'h5555,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,0,0,0,0));
        // Fill three entries again, then reset mid-burst with activity on both inputs
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,0,1,'h28+i,'hA000+i,1,'h18+i,'hB000+i, 1,1,'h28+i,'hA000+i,0));
        vecs.push_back(mk(1,0,1,'h3F,'hABCD,1,'h1F,'hBEEF, 1,0,0,0,0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,0,0,0,0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            #1;
            compare($sformatf("v%0d copper_write_ready", i), 32'(bus.copper_write_ready), 32'(vecs[i].erdy));
            @(posedge clk);
            #1;
            checkOutput(vecs[i], i);
            @(negedge clk);
        end

        compare("scoreboard drained", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
